tx_frame_fifo: RTL and testbench



---
 rtl/tx_frame_fifo.sv | 199 +++++++++++++++++++
 tb/tb_tx_frame_fifo.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_fifo.sv
// Result FIFO feeding a framed SPI transmitter: each queued ALU result goes out as
// little-endian data bytes, a status byte and an optional XOR checksum byte.
module tx_frame_fifo #(
    parameter int RES_W       = 18,
    parameter int DEPTH       = 4,
    parameter int CHECKSUM_EN = 1,
    localparam int LW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_clk,
    input  logic             spi_r,
    input  logic [RES_W-1:0] res_data,
    input  logic             carry_in,
    input  logic             res_valid,
    output logic             res_ready,
    output logic [7:0]       miso,
    output logic             miso_valid,
    output logic             carry_out,
    output logic             tx_done,
    output logic             tx_abort,
    output logic [LW-1:0]    fifo_level
);
    localparam int DB     = (RES_W + 7) / 8;
    localparam int NBYTES = DB + 1 + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int AW     = $clog2(DEPTH);
    localparam int IW     = $clog2(NBYTES);
    localparam int EW     = RES_W + 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q, sync3_q;
    logic             spiRise;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [IW-1:0]    byteIdx_q, byteIdx_d;
    logic [7:0]       frame_q [NBYTES];
    logic [7:0]       frame_d [NBYTES];
    logic             abortFlag_q, abortFlag_d;
    logic [7:0]       misoByte_q, misoByte_d;
    logic             misoValid_q, misoValid_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             abortPulse_q, abortPulse_d;

    logic             push, pop;
    logic [EW-1:0]    head;
    logic [LW-1:0]    levelAfterPop;
    logic [5:0]       levelSat;
    logic [DB*8-1:0]  dataPad;
    logic [7:0]       checksum;
    logic [7:0]       newFrame [NBYTES];

    assign res_ready  = (level_q != LW'(DEPTH));
    assign push       = res_valid && res_ready;
    assign pop        = (state_q == IDLE) && (level_q != '0) && spi_r;
    assign spiRise    = sync2_q && !sync3_q;

    assign miso       = misoByte_q;
    assign miso_valid = misoValid_q;
    assign carry_out  = carry_q;
    assign tx_done    = done_q;
    assign tx_abort   = abortPulse_q;
    assign fifo_level = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= spi_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wrPtr_q] <= {carry_in, res_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            byteIdx_q    <= '0;
            for (int b = 0; b < NBYTES; b++) begin
                frame_q[b] <= '0;
            end
            abortFlag_q  <= 1'b0;
            misoByte_q   <= '0;
            misoValid_q  <= 1'b0;
            carry_q      <= 1'b0;
            done_q       <= 1'b0;
            abortPulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            level_q      <= level_d;
            byteIdx_q    <= byteIdx_d;
            frame_q      <= frame_d;
            abortFlag_q  <= abortFlag_d;
            misoByte_q   <= misoByte_d;
            misoValid_q  <= misoValid_d;
            carry_q      <= carry_d;
            done_q       <= done_d;
            abortPulse_q <= abortPulse_d;
        end
    end

    // Frame image for the FIFO head; the status byte reports the level left after this pop.
    always_comb begin
        head          = mem_q[rdPtr_q];
        levelAfterPop = level_q - LW'(1);
        levelSat      = (32'(levelAfterPop) > 32'd63) ? 6'd63 : 6'(levelAfterPop);
        dataPad       = (DB*8)'(head[RES_W-1:0]);
        checksum      = '0;
        for (int b = 0; b < NBYTES; b++) begin
            newFrame[b] = '0;
        end
        for (int b = 0; b < DB; b++) begin
            newFrame[b] = dataPad[b*8 +: 8];
            checksum    = checksum ^ dataPad[b*8 +: 8];
        end
        newFrame[DB] = {head[RES_W], abortFlag_q, levelSat};
        checksum     = checksum ^ newFrame[DB];
        if (CHECKSUM_EN != 0) begin
            newFrame[NBYTES-1] = checksum;
        end
    end

    always_comb begin
        state_d      = state_q;
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        level_d      = level_q;
        byteIdx_d    = byteIdx_q;
        frame_d      = frame_q;
        abortFlag_d  = abortFlag_q;
        misoByte_d   = misoByte_q;
        misoValid_d  = 1'b0;
        carry_d      = carry_q;
        done_d       = 1'b0;
        abortPulse_d = 1'b0;

        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    frame_d     = newFrame;
                    byteIdx_d   = '0;
                    carry_d     = head[RES_W];
                    abortFlag_d = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                // Dropping the read enable abandons the frame; the popped entry is lost.
                if (!spi_r) begin
                    state_d      = IDLE;
                    abortPulse_d = 1'b1;
                    abortFlag_d  = 1'b1;
                end else if (spiRise) begin
                    misoByte_d  = frame_q[byteIdx_q];
                    misoValid_d = 1'b1;
                    byteIdx_d   = byteIdx_q + IW'(1);
                    if (byteIdx_q == IW'(NBYTES - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_frame_fifo.sv
// Self-checking bench for tx_frame_fifo: a wide checksummed instance and a narrow
// 8-bit instance without checksum, compared against a byte-level frame model.
module tb_tx_frame_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        spi_clk;
    logic        spi_r;

    logic [17:0] res_data;
    logic        carry_in;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  miso;
    logic        miso_valid;
    logic        carry_out;
    logic        tx_done;
    logic        tx_abort;
    logic [2:0]  fifo_level;

    logic [7:0]  res_data8;
    logic        carry_in8;
    logic        res_valid8;
    logic        res_ready8;
    logic [7:0]  miso8;
    logic        miso_valid8;
    logic        carry_out8;
    logic        tx_done8;
    logic        tx_abort8;
    logic [2:0]  fifo_level8;

    int          checks = 0;
    int          errors = 0;
    int          abortCount = 0;
    logic [8:0]  got[$];
    logic [8:0]  got8[$];
    logic [8:0]  expQ[$];

    always #5 clk = ~clk;

    tx_frame_fifo #(.RES_W(18), .DEPTH(4), .CHECKSUM_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_r(spi_r),
        .res_data(res_data), .carry_in(carry_in), .res_valid(res_valid),
        .res_ready(res_ready), .miso(miso), .miso_valid(miso_valid),
        .carry_out(carry_out), .tx_done(tx_done), .tx_abort(tx_abort),
        .fifo_level(fifo_level)
    );

    tx_frame_fifo #(.RES_W(8), .DEPTH(4), .CHECKSUM_EN(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_r(spi_r),
        .res_data(res_data8), .carry_in(carry_in8), .res_valid(res_valid8),
        .res_ready(res_ready8), .miso(miso8), .miso_valid(miso_valid8),
        .carry_out(carry_out8), .tx_done(tx_done8), .tx_abort(tx_abort8),
        .fifo_level(fifo_level8)
    );

    // Every transmitted byte is logged as {tx_done, miso}.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (miso_valid === 1'b1) got.push_back({tx_done, miso});
            if (miso_valid8 === 1'b1) got8.push_back({tx_done8, miso8});
            if (tx_abort === 1'b1) abortCount++;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void addFrame18(input int d, input int c, input int lvl, input int ab);
        int b[5];
        b[0] = d % 256;
        b[1] = (d / 256) % 256;
        b[2] = d / 65536;
        b[3] = c * 128 + ab * 64 + ((lvl > 63) ? 63 : lvl);
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        for (int i = 0; i < 5; i++) expQ.push_back({(i == 4), 8'(b[i])});
    endfunction

    function automatic void addFrame8(input int d, input int c, input int lvl, input int ab);
        expQ.push_back({1'b0, 8'(d)});
        expQ.push_back({1'b1, 8'(c * 128 + ab * 64 + lvl)});
    endfunction

    task automatic resetDut();
        rst_n = 1'b0;
        spi_clk = 1'b0;
        spi_r = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        carry_in = 1'b0;
        res_valid8 = 1'b0;
        res_data8 = '0;
        carry_in8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got.delete();
        got8.delete();
        expQ.delete();
        abortCount = 0;
    endtask

    task automatic pushResult(input logic [17:0] d, input logic c);
        res_data = d;
        carry_in = c;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic pushResult8(input logic [7:0] d, input logic c);
        res_data8 = d;
        carry_in8 = c;
        res_valid8 = 1'b1;
        @(negedge clk);
        res_valid8 = 1'b0;
    endtask

    task automatic spiPulse(input int hi, input int lo);
        spi_clk = 1'b1;
        repeat (hi) @(negedge clk);
        spi_clk = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_clk = 1'b0;
        spi_r = 1'b0;
        res_valid = 1'b0;
        res_valid8 = 1'b0;
        res_data = '0;
        carry_in = 1'b0;
        res_data8 = '0;
        carry_in8 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 7;
        if (miso !== 8'h00) begin errors++; $display("[TB] FAIL reset_miso: got %h expected 00", miso); end
        if (miso_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso_valid: got %b expected 0", miso_valid); end
        if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b expected 0", carry_out); end
        if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", tx_done); end
        if (tx_abort !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort: got %b expected 0", tx_abort); end
        if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
        if (res_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", res_ready); end
    endtask

    task automatic test_single_frame();
        logic [17:0] d;
        logic        c;
        logic        prevCarry;
        resetDut();
        prevCarry = 1'b0;
        for (int it = 0; it < 5; it++) begin
            d = (it == 0) ? 18'h2ABCD : 18'($urandom);
            c = (it == 0) ? 1'b1 : 1'($urandom);
            got.delete();
            expQ.delete();
            pushResult(d, c);
            checks++;
            if (carry_out !== prevCarry) begin
                errors++; $display("[TB] FAIL single_carry_before: got %b expected %b", carry_out, prevCarry);
            end
            addFrame18(int'(d), int'(c), 0, 0);
            spi_r = 1'b1;
            repeat (3) @(negedge clk);
            checks++;
            if (carry_out !== c) begin
                errors++; $display("[TB] FAIL single_carry_load: got %b expected %b", carry_out, c);
            end
            for (int p = 0; p < 5; p++) spiPulse(3, 3);
            spi_r = 1'b0;
            @(negedge clk);
            prevCarry = c;
            checks++;
            if (got.size() !== expQ.size()) begin
                errors++; $display("[TB] FAIL single_count: got %0d bytes expected %0d", got.size(), expQ.size());
            end
            for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== expQ[i]) begin
                    errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, got[i], expQ[i]);
                end
            end
            if (it == 0 && got.size() == 5) begin
                checks++;
                if (got[4] !== 9'h1E4) begin
                    errors++; $display("[TB] FAIL single_checksum: got %h expected 1e4", got[4]);
                end
            end
        end
    endtask

    task automatic test_fill();
        logic [17:0] vals[5];
        logic        carr[5];
        resetDut();
        for (int i = 0; i < 5; i++) begin
            vals[i] = 18'($urandom);
            carr[i] = (i == 0) ? 1'b0 : 1'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL fill_ready%0d: got %b expected 1", i, res_ready);
            end
            pushResult(vals[i], carr[i]);
        end
        checks += 2;
        if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL fill_level: got %0d expected 4", fifo_level); end
        if (res_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_ready_full: got %b expected 0", res_ready); end
        res_data = vals[4];
        carry_in = carr[4];
        res_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("[TB] FAIL fill_held_off: got %0d expected 4", fifo_level); end
        res_valid = 1'b0;
        for (int i = 0; i < 4; i++) addFrame18(int'(vals[i]), int'(carr[i]), 3 - i, 0);
        spi_r = 1'b1;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 20; p++) spiPulse(3, 3);
        spi_r = 1'b0;
        @(negedge clk);
        checks++;
        if (got.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL fill_count: got %0d bytes expected %0d", got.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expQ[i]) begin
                errors++; $display("[TB] FAIL fill_byte%0d: got %h expected %h", i, got[i], expQ[i]);
            end
        end
        if (got.size() > 3) begin
            checks++;
            if (got[3][7:0] !== 8'h03) begin
                errors++; $display("[TB] FAIL fill_status0: got %h expected 03", got[3][7:0]);
            end
        end
        checks++;
        if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL fill_drained: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_abort();
        logic [17:0] a, b;
        logic        ca, cb;
        resetDut();
        a = 18'($urandom);
        b = 18'($urandom);
        ca = 1'($urandom);
        cb = 1'($urandom);
        pushResult(18'h00011, 1'b0);
        pushResult(a, ca);
        pushResult(b, cb);
        spi_r = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL abort_level_load: got %0d expected 2", fifo_level); end
        spiPulse(3, 3);
        spiPulse(3, 3);
        spi_r = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (abortCount !== 1) begin errors++; $display("[TB] FAIL abort_pulse: got %0d expected 1", abortCount); end
        if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL abort_level: got %0d expected 2", fifo_level); end
        if (miso !== 8'h00) begin errors++; $display("[TB] FAIL abort_miso_hold: got %h expected 00", miso); end
        if (got.size() !== 2) begin
            errors++; $display("[TB] FAIL abort_partial_count: got %0d expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== 9'h011 || got[1] !== 9'h000) begin
                errors++; $display("[TB] FAIL abort_partial_bytes: got %h %h expected 011 000", got[0], got[1]);
            end
        end
        got.delete();
        expQ.delete();
        addFrame18(int'(a), int'(ca), 1, 1);
        addFrame18(int'(b), int'(cb), 0, 0);
        spi_r = 1'b1;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 10; p++) spiPulse(3, 3);
        spi_r = 1'b0;
        @(negedge clk);
        checks += 2;
        if (abortCount !== 1) begin errors++; $display("[TB] FAIL abort_no_extra: got %0d expected 1", abortCount); end
        if (got.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL abort_count: got %0d bytes expected %0d", got.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expQ[i]) begin
                errors++; $display("[TB] FAIL abort_byte%0d: got %h expected %h", i, got[i], expQ[i]);
            end
        end
    endtask

    task automatic test_narrow();
        logic [7:0] v[3];
        logic       cv[3];
        resetDut();
        pushResult8(8'h5A, 1'b0);
        addFrame8(32'h5A, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            v[i] = 8'($urandom);
            cv[i] = 1'($urandom);
        end
        spi_r = 1'b1;
        repeat (3) @(negedge clk);
        spiPulse(3, 3);
        spiPulse(3, 3);
        spi_r = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) pushResult8(v[i], cv[i]);
        for (int i = 0; i < 3; i++) addFrame8(int'(v[i]), int'(cv[i]), 2 - i, 0);
        spi_r = 1'b1;
        repeat (3) @(negedge clk);
        for (int p = 0; p < 6; p++) spiPulse(3, 3);
        spi_r = 1'b0;
        @(negedge clk);
        checks += 3;
        if (carry_out8 !== cv[2]) begin errors++; $display("[TB] FAIL narrow_carry: got %b expected %b", carry_out8, cv[2]); end
        if (got.size() !== 0) begin errors++; $display("[TB] FAIL narrow_wide_idle: got %0d bytes expected 0", got.size()); end
        if (got8.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL narrow_count: got %0d bytes expected %0d", got8.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < got8.size(); i++) begin
            checks++;
            if (got8[i] !== expQ[i]) begin
                errors++; $display("[TB] FAIL narrow_byte%0d: got %h expected %h", i, got8[i], expQ[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [17:0] v0, v1, v2;
        resetDut();
        v0 = 18'($urandom);
        v1 = 18'($urandom);
        v2 = 18'($urandom);
        pushResult(v0, 1'b1);
        pushResult(v1, 1'b0);
        checks++;
        if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_pre: got %0d expected 2", fifo_level); end
        res_data = v2;
        carry_in = 1'b0;
        res_valid = 1'b1;
        spi_r = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        checks += 2;
        if (fifo_level !== 3'd2) begin errors++; $display("[TB] FAIL pushpop_level: got %0d expected 2", fifo_level); end
        if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_carry: got %b expected 1", carry_out); end
        repeat (2) @(negedge clk);
        spiPulse(3, 3);
        spiPulse(3, 3);
        checks++;
        if (got.size() !== 2) begin
            errors++; $display("[TB] FAIL pushpop_count: got %0d expected 2", got.size());
        end else begin
            checks++;
            if (got[0] !== {1'b0, v0[7:0]} || got[1] !== {1'b0, v0[15:8]}) begin
                errors++; $display("[TB] FAIL pushpop_bytes: got %h %h expected %h %h",
                                   got[0], got[1], {1'b0, v0[7:0]}, {1'b0, v0[15:8]});
            end
        end
        rst_n = 1'b0;
        #1;
        checks += 7;
        if (miso !== 8'h00) begin errors++; $display("[TB] FAIL midreset_miso: got %h expected 00", miso); end
        if (miso_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", miso_valid); end
        if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL midreset_carry: got %b expected 0", carry_out); end
        if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", tx_done); end
        if (tx_abort !== 1'b0) begin errors++; $display("[TB] FAIL midreset_abort: got %b expected 0", tx_abort); end
        if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL midreset_level: got %0d expected 0", fifo_level); end
        if (res_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", res_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got.delete();
        for (int p = 0; p < 5; p++) spiPulse(3, 3);
        spi_r = 1'b0;
        @(negedge clk);
        checks += 2;
        if (got.size() !== 0) begin errors++; $display("[TB] FAIL midreset_discard: got %0d bytes expected 0", got.size()); end
        if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL midreset_level_after: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] v[2];
        logic        cv[2];
        resetDut();
        for (int i = 0; i < 2; i++) begin
            v[i] = 18'($urandom);
            cv[i] = 1'($urandom);
            pushResult(v[i], cv[i]);
            addFrame18(int'(v[i]), int'(cv[i]), 1 - i, 0);
        end
        spi_r = 1'b1;
        repeat (2) @(negedge clk);
        // spi_clk phases of 1..3 clk cycles; the surplus pulses land on an empty FIFO.
        for (int p = 0; p < 13; p++) spiPulse($urandom_range(1, 3), $urandom_range(1, 3));
        repeat (4) @(negedge clk);
        spi_r = 1'b0;
        @(negedge clk);
        checks++;
        if (got.size() !== expQ.size()) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d bytes expected %0d", got.size(), expQ.size());
        end
        for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== expQ[i]) begin
                errors++; $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, got[i], expQ[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fill();
        test_abort();
        test_narrow();
        test_push_pop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
